// File: rtl/serial_cmp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_cmp_ctrl
//  Brief    : Sequential unsigned magnitude comparator. Walks the operands
//             MSB-first one 2-bit digit pair per cycle through a single
//             2-bit greater-than slice evaluated in both directions, and
//             stops at the first differing digit. Start/done handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_cmp_ctrl #(
  parameter int WIDTH = 8,                    // must be even and >= 2
  parameter int CW    = $clog2(WIDTH/2) + 1   // width of digits_used
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [CW-1:0]    digits_used
);

  localparam int DIGITS = WIDTH / 2;
  // Digit index width; a single-digit operand still needs a 1-bit index.
  localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);
  localparam logic [CW-1:0] DIGITS_CW = CW'(DIGITS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // 2-bit unsigned greater-than slice: x > y.
  function automatic logic gt2(input logic [1:0] x, input logic [1:0] y);
    return (x[1] & ~y[1]) | ((x[1] ~^ y[1]) & x[0] & ~y[0]);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic [CW-1:0]    du_q, du_d;

  // Latched operands viewed as arrays of 2-bit digits.
  logic [1:0] ra_dig [DIGITS];
  logic [1:0] rb_dig [DIGITS];

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign ra_dig[gi] = ra_q[2*gi +: 2];
    assign rb_dig[gi] = rb_q[2*gi +: 2];
  end

  logic [1:0] dig_a;
  logic [1:0] dig_b;
  logic       a_gt_b;
  logic       b_gt_a;
  logic       last_digit;
  logic       decided;

  // The one slice is evaluated with its inputs swapped for the b>a direction.
  assign dig_a      = ra_dig[idx_q];
  assign dig_b      = rb_dig[idx_q];
  assign a_gt_b     = gt2(dig_a, dig_b);
  assign b_gt_a     = gt2(dig_b, dig_a);
  assign last_digit = (idx_q == '0);
  assign decided    = a_gt_b | b_gt_a | last_digit;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: RUN leaves on the first differing digit or after the LSB digit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (decided) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded handshake outputs.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_RUN:   busy = 1'b1;
      S_DONE:  begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath next values: operand capture on accept, digit walk and result update in RUN.
  always_comb begin
    ra_d  = ra_q;
    rb_d  = rb_q;
    idx_d = idx_q;
    gt_d  = gt_q;
    eq_d  = eq_q;
    lt_d  = lt_q;
    du_d  = du_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ra_d  = a;
          rb_d  = b;
          idx_d = IDX_MAX;
          gt_d  = 1'b0;
          eq_d  = 1'b0;
          lt_d  = 1'b0;
          du_d  = '0;
        end
      end
      S_RUN: begin
        if (a_gt_b) begin
          gt_d = 1'b1;
        end else if (b_gt_a) begin
          lt_d = 1'b1;
        end else if (last_digit) begin
          eq_d = 1'b1;
        end else begin
          idx_d = idx_q - IW'(1);
        end
        // idx counts down from the MSB digit, so pairs examined = DIGITS - idx.
        if (decided) begin
          du_d = DIGITS_CW - CW'(idx_q);
        end
      end
      default: begin
        ra_d = ra_q;
      end
    endcase
  end

  // Datapath registers; results hold until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra_q  <= '0;
      rb_q  <= '0;
      idx_q <= '0;
      gt_q  <= 1'b0;
      eq_q  <= 1'b0;
      lt_q  <= 1'b0;
      du_q  <= '0;
    end else begin
      ra_q  <= ra_d;
      rb_q  <= rb_d;
      idx_q <= idx_d;
      gt_q  <= gt_d;
      eq_q  <= eq_d;
      lt_q  <= lt_d;
      du_q  <= du_d;
    end
  end

  assign gt          = gt_q;
  assign eq          = eq_q;
  assign lt          = lt_q;
  assign digits_used = du_q;

endmodule
`default_nettype wire
